// File: rtl/fetch_pc_ctrl_if.sv
// Sram-like instruction port between the fetch PC controller (master) and the
// instruction SRAM bridge (slave): one request/accept handshake plus a data return.
interface fetch_pc_ctrl_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: keeps at most one request outstanding on the instruction
// port, parks redirects until the port can take them, and buffers one fetched instruction.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'hbfc00000,
  parameter logic [31:0] EXC_ENTRY = 32'hbfc00380
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            stallF,
  input  logic            is_pc_exception,
  input  logic            is_pc_eret,
  input  logic [31:0]     epc,
  input  logic            is_pc_jump,
  input  logic [31:0]     pc_jD,
  input  logic            is_pc_branch,
  input  logic [31:0]     pc_branchD,
  fetch_pc_ctrl_if.master imem,
  output logic            fetch_valid,
  output logic [31:0]     fetch_pc,
  output logic [31:0]     fetch_inst
);

  typedef enum logic [1:0] { S_REQ, S_WAIT, S_CANCEL } state_t;

  // Redirect ranking; the two flushing kinds sit above the two non-flushing ones.
  typedef enum logic [1:0] { P_BRANCH, P_JUMP, P_ERET, P_EXC } prio_t;

  typedef struct packed {
    logic        valid;
    prio_t       prio;
    logic [31:0] target;
  } redir_t;

  localparam redir_t NO_REDIR = '{valid: 1'b0, prio: P_BRANCH, target: 32'h0};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  redir_t      pend_q, pend_d;
  redir_t      redir_now;
  redir_t      redir_merged;
  logic        redir_flush;
  logic        req_flush_q, req_flush_d;
  logic [31:0] cap_pc_q, cap_pc_d;
  logic        fetch_valid_d;
  logic        req;
  logic        accept;
  logic        load;

  // ---------------------------------------------------------------------------
  // Redirect selection and merge with the parked entry
  // ---------------------------------------------------------------------------
  assign redir_flush = is_pc_exception | is_pc_eret;

  always_comb begin
    redir_now = NO_REDIR;
    if (is_pc_exception)   redir_now = '{valid: 1'b1, prio: P_EXC,    target: EXC_ENTRY};
    else if (is_pc_eret)   redir_now = '{valid: 1'b1, prio: P_ERET,   target: epc};
    else if (is_pc_jump)   redir_now = '{valid: 1'b1, prio: P_JUMP,   target: pc_jD};
    else if (is_pc_branch) redir_now = '{valid: 1'b1, prio: P_BRANCH, target: pc_branchD};
  end

  // A newcomer replaces the parked redirect only if it ranks at least as high.
  always_comb begin
    redir_merged = pend_q;
    if (redir_now.valid && (!pend_q.valid || (redir_now.prio >= pend_q.prio)))
      redir_merged = redir_now;
  end

  // ---------------------------------------------------------------------------
  // Instruction port
  // ---------------------------------------------------------------------------
  // Once raised, req stays high until accepted: the buffer is either empty or
  // draining, so it is empty on the following cycle.
  assign req           = resetn && (state_q == S_REQ) && (!stallF || !fetch_valid);
  assign accept        = req && imem.inst_addr_ok;
  assign imem.inst_req  = req;
  assign imem.inst_addr = pc_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    req_flush_d = req_flush_q;
    cap_pc_d    = cap_pc_q;
    load        = 1'b0;

    case (state_q)
      S_REQ: begin
        if (!req) begin
          // Port idle: redirect takes effect on pc straight away.
          if (redir_merged.valid) pc_d = redir_merged.target;
          pend_d      = NO_REDIR;
          req_flush_d = 1'b0;
        end else if (accept) begin
          cap_pc_d    = pc_q;
          pc_d        = redir_merged.valid ? redir_merged.target : pc_q + 32'd4;
          pend_d      = NO_REDIR;
          req_flush_d = 1'b0;
          state_d     = (req_flush_q || redir_flush) ? S_CANCEL : S_WAIT;
        end else begin
          // Address must stay stable while unaccepted, so park the redirect.
          pend_d      = redir_merged;
          req_flush_d = req_flush_q | redir_flush;
        end
      end

      S_WAIT: begin
        if (imem.inst_data_ok) begin
          load    = !redir_flush;
          state_d = S_REQ;
          if (redir_merged.valid) pc_d = redir_merged.target;
          pend_d  = NO_REDIR;
        end else begin
          pend_d = redir_merged;
          if (redir_flush) state_d = S_CANCEL;
        end
      end

      S_CANCEL: begin
        if (imem.inst_data_ok) begin
          state_d = S_REQ;
          if (redir_merged.valid) pc_d = redir_merged.target;
          pend_d  = NO_REDIR;
        end else begin
          pend_d = redir_merged;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  // Output buffer: a flush beats both a load and a hold.
  always_comb begin
    fetch_valid_d = fetch_valid;
    if (redir_flush)  fetch_valid_d = 1'b0;
    else if (load)    fetch_valid_d = 1'b1;
    else if (!stallF) fetch_valid_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      pend_q      <= NO_REDIR;
      req_flush_q <= 1'b0;
      cap_pc_q    <= 32'h0;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'h0;
      fetch_inst  <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      req_flush_q <= req_flush_d;
      cap_pc_q    <= cap_pc_d;
      fetch_valid <= fetch_valid_d;
      if (load) begin
        fetch_pc   <= cap_pc_q;
        fetch_inst <= imem.inst_rdata;
      end
    end
  end

endmodule
